// File: rtl/mux_n_pipe_if.sv
// Bus bundle for mux_n_pipe: producer side (In/Sel/in_valid/in_ready),
// consumer side (Out/out_valid/out_ready) and the sticky sel_err flag.
interface mux_n_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SEL_W = 2
);
  // Handshake: a beat transfers on a rising edge where valid && ready.
  // in_ready and out_valid come from registered state only, so neither side
  // ever sees a combinational path through the block; the producer holds
  // In/Sel/in_valid stable until the beat is accepted.
  logic [N*WIDTH-1:0] In;
  logic [SEL_W-1:0]   Sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   Out;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  modport master (
    output In, Sel, in_valid, out_ready,
    input  in_ready, Out, out_valid, sel_err
  );

  modport slave (
    input  In, Sel, in_valid, out_ready,
    output in_ready, Out, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input select mux behind a two-entry skid buffer (OREG + SREG).
// Optional sticky illegal-select flag enabled by MUX_N_PIPE_SEL_ERR_EN.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_n_pipe_if.slave      bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] oreg, sreg, last_legal;
  logic [WIDTH-1:0] pick;
  logic             sel_legal;
  logic             accept, pop;
  logic             load_o, load_s, o_from_s;

  // Illegal selects fall back to the last legal data, resolved at accept time.
  always_comb begin
    pick      = last_legal;
    sel_legal = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.Sel == SEL_W'(k)) begin
        pick      = bus.In[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.Out       = oreg;
  assign dbg_state     = state;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n  = state;
    load_o   = 1'b0;
    load_s   = 1'b0;
    o_from_s = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_o  = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_o = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_n = TWO;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          o_from_s = 1'b1;
          state_n  = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      oreg       <= '0;
      sreg       <= '0;
      last_legal <= '0;
    end else begin
      state <= state_n;
      if (load_o)        oreg <= pick;
      else if (o_from_s) oreg <= sreg;
      if (load_s)        sreg <= pick;
      if (accept && sel_legal) last_legal <= pick;
    end
  end

`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (accept && !sel_legal) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and random checks of mux_n_pipe: a 32-bit/N=3 instance for the
// directed steps and an 8-bit/N=4 instance (3-bit Sel) for the random stream.
module tb_mux_n_pipe;

`ifdef MUX_N_PIPE_SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // State encoding as exposed on dbg_state.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic clk;
  logic rst_a, rst_b;
  logic [1:0] dbg_a, dbg_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q_a[$];
  logic [7:0]  exp_q_b[$];
  logic [31:0] last_a;
  logic [7:0]  last_b;
  logic        hold_b;
  logic [7:0]  hold_out_b;

  mux_n_pipe_if #(.WIDTH(32), .N(3), .SEL_W(2)) bus_a ();
  mux_n_pipe_if #(.WIDTH(8),  .N(4), .SEL_W(3)) bus_b ();

  mux_n_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  mux_n_pipe #(.WIDTH(8), .N(4), .SEL_W(3)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock for instance A: score at the falling edge, return #1 after rise.
  task automatic tick_a();
    @(negedge clk);
    if (rst_a) begin
      exp_q_a.delete();
      last_a = '0;
    end else begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (exp_q_a.size() == 0) check("a_spurious_pop", 32'd1, 32'd0);
        else check("a_out", bus_a.Out, exp_q_a.pop_front());
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        if (bus_a.Sel < 2'd3) last_a = bus_a.In[bus_a.Sel*32 +: 32];
        exp_q_a.push_back(last_a);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(output logic acc);
    @(negedge clk);
    acc = 1'b0;
    if (rst_b) begin
      exp_q_b.delete();
      last_b = '0;
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        check("b_valid_hold", {31'd0, bus_b.out_valid}, 32'd1);
        check("b_out_hold", {24'd0, bus_b.Out}, {24'd0, hold_out_b});
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (exp_q_b.size() == 0) check("b_spurious_pop", 32'd1, 32'd0);
        else check("b_out", {24'd0, bus_b.Out}, {24'd0, exp_q_b.pop_front()});
      end
      acc = bus_b.in_valid && bus_b.in_ready;
      if (acc) begin
        if (bus_b.Sel < 3'd4) last_b = bus_b.In[bus_b.Sel*8 +: 8];
        exp_q_b.push_back(last_b);
      end
      hold_b     = bus_b.out_valid && !bus_b.out_ready;
      hold_out_b = bus_b.Out;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    last_a = '0;
    last_b = '0;
    hold_b = 1'b0;
    hold_out_b = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.In = '0; bus_a.Sel = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.In = '0; bus_b.Sel = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    tick_a();
    tick_a();
    rst_a = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("rst_out", bus_a.Out, 32'd0);
    check("rst_sel_err", {31'd0, bus_a.sel_err}, 32'd0);
    check("rst_state", {30'd0, dbg_a}, {30'd0, S_EMPTY});

    // Streaming at full rate, one cycle latency from EMPTY
    bus_a.In = {32'h33, 32'h22, 32'h11};
    bus_a.out_ready = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.Sel = 2'd0;
    tick_a();
    check("strm_out0", bus_a.Out, 32'h11);
    check("strm_valid0", {31'd0, bus_a.out_valid}, 32'd1);
    check("strm_ready0", {31'd0, bus_a.in_ready}, 32'd1);
    bus_a.Sel = 2'd1;
    tick_a();
    check("strm_out1", bus_a.Out, 32'h22);
    check("strm_ready1", {31'd0, bus_a.in_ready}, 32'd1);
    bus_a.Sel = 2'd2;
    tick_a();
    check("strm_out2", bus_a.Out, 32'h33);
    check("strm_ready2", {31'd0, bus_a.in_ready}, 32'd1);
    bus_a.in_valid = 1'b0;
    tick_a();
    check("strm_empty", {31'd0, bus_a.out_valid}, 32'd0);

    // Backpressure: fill ONE then TWO, third waits until the first pop
    bus_a.In = {32'h0c, 32'h0b, 32'h0a};
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.Sel = 2'd0;
    tick_a();
    check("bp_state_one", {30'd0, dbg_a}, {30'd0, S_ONE});
    check("bp_ready_one", {31'd0, bus_a.in_ready}, 32'd1);
    bus_a.Sel = 2'd1;
    tick_a();
    check("bp_state_two", {30'd0, dbg_a}, {30'd0, S_TWO});
    check("bp_ready_two", {31'd0, bus_a.in_ready}, 32'd0);
    check("bp_out_head", bus_a.Out, 32'h0a);
    bus_a.Sel = 2'd2;
    tick_a();
    check("bp_stall_ready", {31'd0, bus_a.in_ready}, 32'd0);
    check("bp_stall_out", bus_a.Out, 32'h0a);
    bus_a.out_ready = 1'b1;
    tick_a();
    check("bp_pop1_out", bus_a.Out, 32'h0b);
    check("bp_pop1_ready", {31'd0, bus_a.in_ready}, 32'd1);
    tick_a();
    check("bp_third_out", bus_a.Out, 32'h0c);
    check("bp_third_state", {30'd0, dbg_a}, {30'd0, S_ONE});
    bus_a.in_valid = 1'b0;
    tick_a();
    check("bp_drained", {31'd0, bus_a.out_valid}, 32'd0);

    // Illegal select reuses the last legal data
    bus_a.In = {32'h33, 32'h22, 32'h11};
    bus_a.in_valid = 1'b1;
    bus_a.Sel = 2'd1;
    tick_a();
    check("ill_legal_out", bus_a.Out, 32'h22);
    check("ill_err_before", {31'd0, bus_a.sel_err}, 32'd0);
    bus_a.Sel = 2'd3;
    tick_a();
    check("ill_out", bus_a.Out, 32'h22);
    check("ill_err", {31'd0, bus_a.sel_err}, {31'd0, EXP_ERR});
    bus_a.in_valid = 1'b0;
    tick_a();
    check("ill_err_sticky", {31'd0, bus_a.sel_err}, {31'd0, EXP_ERR});

    // Reset while full with in_valid high
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.Sel = 2'd0;
    tick_a();
    bus_a.Sel = 2'd2;
    tick_a();
    check("mid_state_two", {30'd0, dbg_a}, {30'd0, S_TWO});
    rst_a = 1'b1;
    tick_a();
    rst_a = 1'b0;
    bus_a.in_valid = 1'b0;
    check("mid_rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check("mid_rst_out", bus_a.Out, 32'd0);
    check("mid_rst_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("mid_rst_err", {31'd0, bus_a.sel_err}, 32'd0);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_a();
      check("mid_no_stale", {31'd0, bus_a.out_valid}, 32'd0);
    end
    check("a_queue_empty", exp_q_a.size(), 32'd0);

    // Random stream on the 8-bit, 4-input instance
    tick_b(acc);
    tick_b(acc);
    rst_b = 1'b0;
    check("b_rst_valid", {31'd0, bus_b.out_valid}, 32'd0);
    check("b_rst_ready", {31'd0, bus_b.in_ready}, 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (acc || !bus_b.in_valid) begin
        bus_b.in_valid = ($urandom_range(0, 3) != 0);
        bus_b.In = $urandom;
        bus_b.Sel = 3'($urandom_range(0, 5));
      end
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      tick_b(acc);
    end
    bus_b.in_valid = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick_b(acc);
    check("b_drain_queue", exp_q_b.size(), 32'd0);
    check("b_drain_valid", {31'd0, bus_b.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
